// File: rtl/dvbt2_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dvbt2_ram_pkg
// Description : Shared types and constants for the DVB-T2 on-chip RAM
//               responder: FSM state encoding, default burst limit and
//               err_flags bit positions.
// Revision    : 1.0  initial release
// ============================================================================
package dvbt2_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2
    } state_t;

    localparam int c_max_burst_default = 16;

    // err_flags bit positions
    localparam int c_err_occ   = 0;  // occupancy underflow / overflow
    localparam int c_err_proto = 1;  // malformed or out-of-place command

endpackage
`default_nettype wire

// File: rtl/dvbt2_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dvbt2_ram_responder_if
// Description : Modulator <-> frame-buffer burst interface (ram_* bus) plus
//               the error-flag side channel to the register block.
//   master : modulator side (drives commands, write data, err_clear)
//   slave  : responder side (drives read data, status, err_flags)
// Revision    : 1.0  initial release
// ============================================================================
interface dvbt2_ram_responder_if;

    logic        ram_cs;
    logic        ram_burst_access;
    logic [3:0]  ram_burst_size;
    logic [23:0] ram_address;
    logic        ram_wr_en;
    logic [31:0] ram_wrdata;
    logic        ram_rd_en;
    logic [31:0] ram_rddata;
    logic        ram_rddata_valid;
    logic        ram_busy;
    logic        ram_available;
    logic        ram_empty;
    logic [1:0]  err_flags;
    logic        err_clear;

    modport master (
        output ram_cs, ram_burst_access, ram_burst_size, ram_address,
               ram_wr_en, ram_wrdata, ram_rd_en, err_clear,
        input  ram_rddata, ram_rddata_valid, ram_busy, ram_available,
               ram_empty, err_flags
    );

    modport slave (
        input  ram_cs, ram_burst_access, ram_burst_size, ram_address,
               ram_wr_en, ram_wrdata, ram_rd_en, err_clear,
        output ram_rddata, ram_rddata_valid, ram_busy, ram_available,
               ram_empty, err_flags
    );

endinterface
`default_nettype wire

// File: rtl/dvbt2_ram_dpram.sv
`default_nettype none
// ============================================================================
// Module      : dvbt2_ram_dpram
// Description : Simple dual-port synchronous RAM, 2^ADDR_W x DATA_W.
//               One write port, one read port, registered 1-cycle read.
//               Contents are deliberately not reset.
//   clk     : clock
//   i_we    : write enable     i_waddr / i_wdata : write address / data
//   i_re    : read enable      i_raddr           : read address
//   o_rdata : read data, valid the cycle after i_re
// Revision    : 1.0  initial release
// ============================================================================
module dvbt2_ram_dpram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    localparam int c_depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [0:c_depth-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dvbt2_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : dvbt2_ram_responder
// Description : Memory-side responder for the modulator ram_* burst bus.
//               Serves single/burst reads and writes from an on-chip frame
//               buffer, tracks occupancy and raises sticky error flags.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : ram_* command/data bus and err_flags/err_clear (slave side)
// Revision    : 1.0  initial release
// ============================================================================
module dvbt2_ram_responder
    import dvbt2_ram_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MAX_BURST = c_max_burst_default
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    dvbt2_ram_responder_if.slave  bus
);

    localparam int               c_occ_w      = ADDR_W + 1;
    localparam logic [ADDR_W:0]  c_full_words = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [4:0]          left_q, left_d;      // beats still to write / reads still to issue
    logic [ADDR_W:0]     occ_q, occ_d;
    logic                rd_pend_q, rd_pend_d; // RAM read issued last cycle
    logic                rdvalid_q, rdvalid_d;
    logic [31:0]         rddata_q, rddata_d;
    logic                busy_q, busy_d;
    logic                empty_q, empty_d;
    logic                avail_q, avail_d;
    logic [1:0]          err_q, err_d;

    logic                w_ram_we;
    logic                w_ram_re;
    logic [ADDR_W-1:0]   w_ram_waddr;
    logic [ADDR_W-1:0]   w_ram_raddr;
    logic [31:0]         w_ram_rdata;
    logic [4:0]          w_cmd_len;
    logic [ADDR_W-1:0]   w_addr_lo;
    logic                w_occ_inc;
    logic                w_occ_dec;
    logic [1:0]          w_err_set;
    logic [ADDR_W:0]     w_free;

    assign w_addr_lo = bus.ram_address[ADDR_W-1:0];
    assign w_cmd_len = bus.ram_burst_access ? ({1'b0, bus.ram_burst_size} + 5'd1) : 5'd1;

    generate
        if (ADDR_W < 24) begin : g_addr_unused
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^bus.ram_address[23:ADDR_W];
        end
    endgenerate

    dvbt2_ram_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_dpram (
        .clk     (clock),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (bus.ram_wrdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        left_d      = left_q;
        occ_d       = occ_q;
        rd_pend_d   = 1'b0;
        rdvalid_d   = rd_pend_q;
        rddata_d    = rd_pend_q ? w_ram_rdata : rddata_q;
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_waddr = ptr_q;
        w_ram_raddr = ptr_q;
        w_occ_inc   = 1'b0;
        w_occ_dec   = 1'b0;
        w_err_set   = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (bus.ram_cs) begin
                    if (bus.ram_wr_en && !bus.ram_rd_en) begin
                        w_ram_we    = 1'b1;
                        w_ram_waddr = w_addr_lo;
                        w_occ_inc   = 1'b1;
                        ptr_d       = w_addr_lo + ADDR_W'(1);
                        left_d      = w_cmd_len - 5'd1;
                        if (w_cmd_len > 5'd1) begin
                            state_d = ST_WR_BURST;
                        end
                    end else if (bus.ram_rd_en && !bus.ram_wr_en) begin
                        w_ram_re    = 1'b1;
                        w_ram_raddr = w_addr_lo;
                        w_occ_dec   = 1'b1;
                        rd_pend_d   = 1'b1;
                        ptr_d       = w_addr_lo + ADDR_W'(1);
                        left_d      = w_cmd_len - 5'd1;
                        state_d     = ST_RD_BURST;
                    end else begin
                        w_err_set[c_err_proto] = 1'b1;
                    end
                end
            end
            ST_WR_BURST: begin
                if (bus.ram_cs) begin
                    if (bus.ram_rd_en) begin
                        // a read strobe inside a write burst is dropped entirely
                        w_err_set[c_err_proto] = 1'b1;
                    end else if (bus.ram_wr_en) begin
                        w_ram_we  = 1'b1;
                        w_occ_inc = 1'b1;
                        ptr_d     = ptr_q + ADDR_W'(1);
                        left_d    = left_q - 5'd1;
                        if (left_q == 5'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_RD_BURST: begin
                // Issue remaining reads back-to-back, then hold until the
                // last word has left the output register.
                if (left_q != 5'd0) begin
                    w_ram_re  = 1'b1;
                    w_occ_dec = 1'b1;
                    rd_pend_d = 1'b1;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    left_d    = left_q - 5'd1;
                end else if (!rd_pend_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_occ_inc) begin
            if (occ_q == c_full_words) begin
                w_err_set[c_err_occ] = 1'b1;
            end else begin
                occ_d = occ_q + c_occ_w'(1);
            end
        end
        if (w_occ_dec) begin
            if (occ_q == '0) begin
                w_err_set[c_err_occ] = 1'b1;
            end else begin
                occ_d = occ_q - c_occ_w'(1);
            end
        end

        // status flags are registered from next-state values so they line up
        // with the FSM and counter
        w_free  = c_full_words - occ_d;
        busy_d  = (state_d == ST_RD_BURST);
        empty_d = (occ_d == '0);
        avail_d = (state_d == ST_IDLE) && !busy_d &&
                  ({{(31-ADDR_W){1'b0}}, w_free} >= 32'(MAX_BURST));
        err_d   = bus.err_clear ? 2'b00 : (err_q | w_err_set);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            left_q    <= '0;
            occ_q     <= '0;
            rd_pend_q <= 1'b0;
            rdvalid_q <= 1'b0;
            rddata_q  <= '0;
            busy_q    <= 1'b0;
            empty_q   <= 1'b1;
            avail_q   <= 1'b1;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            left_q    <= left_d;
            occ_q     <= occ_d;
            rd_pend_q <= rd_pend_d;
            rdvalid_q <= rdvalid_d;
            rddata_q  <= rddata_d;
            busy_q    <= busy_d;
            empty_q   <= empty_d;
            avail_q   <= avail_d;
            err_q     <= err_d;
        end
    end

    assign bus.ram_rddata       = rddata_q;
    assign bus.ram_rddata_valid = rdvalid_q;
    assign bus.ram_busy         = busy_q;
    assign bus.ram_available    = avail_q;
    assign bus.ram_empty        = empty_q;
    assign bus.err_flags        = err_q;

endmodule
`default_nettype wire
